// File: rtl/chi_bank_reader_pkg.sv
`default_nettype none
// ============================================================================
// Package : chi_bank_reader_pkg
// Shared definitions for the chi-square bank reader: FSM state encodings,
// default word width and an index-width helper.
// Revision: 1.0 - initial release
// ============================================================================
package chi_bank_reader_pkg;

  // Two-state reader FSM, explicit 1-bit encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  localparam int DEFAULT_PARAMETERBITS = 14;
  localparam int DEFAULT_NWORDS        = 8;

  // Bits needed to index n entries (never less than 1)
  function automatic int idx_bits(input int n);
    int b;
    b = 1;
    while ((1 << b) < n) b++;
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/chi_bank_reader_min_tracker.sv
`default_nettype none
// ============================================================================
// Module  : chi_min_tracker
// Running unsigned minimum and its index over one frame of words. init
// restarts the search, update folds in one word, commit publishes the result
// (including the word presented on that same cycle).
// Revision: 1.0 - initial release
// ============================================================================
module chi_min_tracker
  import chi_bank_reader_pkg::*;
#(
  parameter int WIDTH = DEFAULT_PARAMETERBITS,
  parameter int IDXW  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_init,
  input  logic             i_update,
  input  logic             i_commit,
  input  logic [WIDTH-1:0] i_word,
  input  logic [IDXW-1:0]  i_idx,
  output logic [WIDTH-1:0] o_min_val,
  output logic [IDXW-1:0]  o_min_idx
);

  logic [WIDTH-1:0] run_min_q, run_min_d;
  logic [IDXW-1:0]  run_idx_q, run_idx_d;
  logic [WIDTH-1:0] min_val_q, min_val_d;
  logic [IDXW-1:0]  min_idx_q, min_idx_d;
  logic             w_take;
  logic [WIDTH-1:0] w_cand_min;
  logic [IDXW-1:0]  w_cand_idx;

  // Strict compare: on a tie the earlier (lower) index is kept
  always_comb begin
    w_take     = (i_word < run_min_q);
    w_cand_min = w_take ? i_word : run_min_q;
    w_cand_idx = w_take ? i_idx  : run_idx_q;
  end

  // Next-state for running and published minimum
  always_comb begin
    run_min_d = run_min_q;
    run_idx_d = run_idx_q;
    min_val_d = min_val_q;
    min_idx_d = min_idx_q;
    if (i_init) begin
      run_min_d = '1;
      run_idx_d = '0;
    end else if (i_update) begin
      run_min_d = w_cand_min;
      run_idx_d = w_cand_idx;
    end
    if (i_commit) begin
      min_val_d = w_cand_min;
      min_idx_d = w_cand_idx;
    end
  end

  // Tracker registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_min_q <= '0;
      run_idx_q <= '0;
      min_val_q <= '0;
      min_idx_q <= '0;
    end else begin
      run_min_q <= run_min_d;
      run_idx_q <= run_idx_d;
      min_val_q <= min_val_d;
      min_idx_q <= min_idx_d;
    end
  end

  assign o_min_val = min_val_q;
  assign o_min_idx = min_idx_q;

endmodule
`default_nettype wire

// File: rtl/chi_bank_reader.sv
`default_nettype none
// ============================================================================
// Module  : chi_bank_reader
// Snapshots NWORDS words of the chi-square/parameter bank on START and
// streams them out over VALID/READY with IDX and LAST tags, reporting the
// frame minimum and its index when the frame completes.
// Revision: 1.0 - initial release
// ============================================================================
module chi_bank_reader
  import chi_bank_reader_pkg::*;
#(
  parameter int PARAMETERBITS = DEFAULT_PARAMETERBITS,
  parameter int NWORDS        = DEFAULT_NWORDS,
  parameter int IDXBITS       = idx_bits(NWORDS)
) (
  input  logic                            CLOCK,
  input  logic                            RESET_N,
  input  logic                            START,
  input  logic [NWORDS*PARAMETERBITS-1:0] BANK_IN,
  output logic [PARAMETERBITS-1:0]        DOUT,
  output logic [IDXBITS-1:0]              IDX,
  output logic                            VALID,
  input  logic                            READY,
  output logic                            LAST,
  output logic                            BUSY,
  output logic                            DONE,
  output logic [PARAMETERBITS-1:0]        MIN_VAL,
  output logic [IDXBITS-1:0]              MIN_IDX
);

  localparam logic [IDXBITS-1:0] LAST_IDX = IDXBITS'(NWORDS - 1);

  logic [0:0]               state_q, state_d;
  logic [PARAMETERBITS-1:0] shadow_q [NWORDS];
  logic [PARAMETERBITS-1:0] shadow_d [NWORDS];
  logic [PARAMETERBITS-1:0] dout_q, dout_d;
  logic [IDXBITS-1:0]       idx_q, idx_d;
  logic                     valid_q, valid_d;
  logic                     last_q, last_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic [PARAMETERBITS-1:0] w_bank_words [NWORDS];
  logic [IDXBITS-1:0]       w_next_idx;
  logic                     w_xfer;
  logic                     w_accept;
  logic                     w_final;

  genvar gi;
  generate
    for (gi = 0; gi < NWORDS; gi++) begin : g_unpack
      assign w_bank_words[gi] = BANK_IN[gi*PARAMETERBITS +: PARAMETERBITS];
    end
  endgenerate

  assign w_xfer     = valid_q & READY;
  assign w_accept   = (state_q == ST_IDLE) & START;
  assign w_final    = (state_q == ST_SEND) & w_xfer & last_q;
  assign w_next_idx = idx_q + IDXBITS'(1);

  // FSM state register
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state: leave IDLE on START, return after the LAST transfer
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (START)            state_d = ST_SEND;
      ST_SEND: if (w_xfer && last_q) state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: snapshot on accept, advance the stream on each transfer
  always_comb begin
    shadow_d = shadow_q;
    dout_d   = dout_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    last_d   = last_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (w_accept) begin
      shadow_d = w_bank_words;
      dout_d   = w_bank_words[0];
      idx_d    = '0;
      valid_d  = 1'b1;
      last_d   = 1'b0;
      busy_d   = 1'b1;
    end else if (state_q == ST_SEND && w_xfer) begin
      if (last_q) begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        dout_d = shadow_q[w_next_idx];
        idx_d  = w_next_idx;
        last_d = (w_next_idx == LAST_IDX);
      end
    end
  end

  // Datapath registers, all cleared asynchronously
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NWORDS; i++) shadow_q[i] <= '0;
      dout_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  chi_min_tracker #(
    .WIDTH (PARAMETERBITS),
    .IDXW  (IDXBITS)
  ) u_min (
    .clk       (CLOCK),
    .rst_n     (RESET_N),
    .i_init    (w_accept),
    .i_update  (state_q == ST_SEND && w_xfer),
    .i_commit  (w_final),
    .i_word    (dout_q),
    .i_idx     (idx_q),
    .o_min_val (MIN_VAL),
    .o_min_idx (MIN_IDX)
  );

  assign DOUT  = dout_q;
  assign IDX   = idx_q;
  assign VALID = valid_q;
  assign LAST  = last_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_chi_bank_reader.sv
`default_nettype none
// ============================================================================
// Module  : tb_chi_bank_reader
// Self-checking bench for chi_bank_reader (NWORDS=4, PARAMETERBITS=14).
// Revision: 1.0 - initial release
// ============================================================================
module tb_chi_bank_reader;

  localparam int PB = 14;
  localparam int NW = 4;
  localparam int IB = 2;

  logic             CLOCK = 1'b0;
  logic             RESET_N;
  logic             START;
  logic [NW*PB-1:0] BANK_IN;
  logic [PB-1:0]    DOUT;
  logic [IB-1:0]    IDX;
  logic             VALID;
  logic             READY;
  logic             LAST;
  logic             BUSY;
  logic             DONE;
  logic [PB-1:0]    MIN_VAL;
  logic [IB-1:0]    MIN_IDX;

  int total  = 0;
  int passed = 0;

  logic [PB-1:0] cur_w [NW];
  logic [PB-1:0] exp_w [NW];
  logic [PB-1:0] exp_min, prev_min;
  logic [IB-1:0] exp_midx, prev_midx;

  always #5 CLOCK = ~CLOCK;

  chi_bank_reader #(
    .PARAMETERBITS (PB),
    .NWORDS        (NW),
    .IDXBITS       (IB)
  ) dut (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .START   (START),
    .BANK_IN (BANK_IN),
    .DOUT    (DOUT),
    .IDX     (IDX),
    .VALID   (VALID),
    .READY   (READY),
    .LAST    (LAST),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .MIN_VAL (MIN_VAL),
    .MIN_IDX (MIN_IDX)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Drive a frame request with cur_w; reference result: smallest value, first index holding it
  task automatic start_frame();
    logic [PB-1:0] m;
    for (int i = 0; i < NW; i++) BANK_IN[i*PB +: PB] = cur_w[i];
    START = 1'b1;
    exp_w = cur_w;
    m = exp_w[0];
    foreach (exp_w[i]) if (exp_w[i] < m) m = exp_w[i];
    exp_min = m;
    exp_midx = '0;
    for (int i = NW - 1; i >= 0; i--) if (exp_w[i] == m) exp_midx = IB'(i);
  endtask

  // rmode 0: READY always high, 1: pattern 1,0,0 repeating, 2: random
  task automatic run_frame(input int rmode, input bit disturb);
    int k;
    int cyc;
    bit r;
    @(negedge CLOCK);
    START = 1'b0;
    k = 0;
    cyc = 0;
    while (k < NW && cyc < 200) begin
      chk("valid", 32'(VALID), 32'd1);
      chk("dout", 32'(DOUT), 32'(exp_w[k]));
      chk("idx", 32'(IDX), 32'(k));
      chk("last", 32'(LAST), 32'(k == NW - 1));
      chk("busy", 32'(BUSY), 32'd1);
      chk("done_early", 32'(DONE), 32'd0);
      chk("minval_held", 32'(MIN_VAL), 32'(prev_min));
      chk("minidx_held", 32'(MIN_IDX), 32'(prev_midx));
      case (rmode)
        0:       r = 1'b1;
        1:       r = (cyc % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      READY = r;
      START = disturb && (k == 1);
      if (disturb)
        for (int i = 0; i < NW; i++) BANK_IN[i*PB +: PB] = PB'($urandom);
      @(negedge CLOCK);
      if (r) k++;
      cyc++;
    end
    START = 1'b0;
    chk("transfer_count", 32'(k), 32'(NW));
    chk("done_pulse", 32'(DONE), 32'd1);
    chk("valid_end", 32'(VALID), 32'd0);
    chk("busy_end", 32'(BUSY), 32'd0);
    chk("last_end", 32'(LAST), 32'd0);
    chk("min_val", 32'(MIN_VAL), 32'(exp_min));
    chk("min_idx", 32'(MIN_IDX), 32'(exp_midx));
    prev_min  = exp_min;
    prev_midx = exp_midx;
  endtask

  initial begin
    RESET_N = 1'b0;
    START   = 1'b0;
    READY   = 1'b0;
    BANK_IN = '0;
    prev_min  = '0;
    prev_midx = '0;
    #12;
    chk("rst_dout", 32'(DOUT), 32'd0);
    chk("rst_idx", 32'(IDX), 32'd0);
    chk("rst_valid", 32'(VALID), 32'd0);
    chk("rst_last", 32'(LAST), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_minval", 32'(MIN_VAL), 32'd0);
    chk("rst_minidx", 32'(MIN_IDX), 32'd0);
    @(negedge CLOCK);
    RESET_N = 1'b1;
    @(negedge CLOCK);
    chk("idle_valid", 32'(VALID), 32'd0);

    // Basic frame, READY always high
    cur_w = '{14'd12, 14'd300, 14'd7, 14'd40};
    start_frame();
    run_frame(0, 1'b0);
    chk("fixed_min_val", 32'(MIN_VAL), 32'd7);
    chk("fixed_min_idx", 32'(MIN_IDX), 32'd2);
    @(negedge CLOCK);
    chk("done_one_cycle", 32'(DONE), 32'd0);

    // Same frame with READY stalls
    start_frame();
    run_frame(1, 1'b0);
    @(negedge CLOCK);
    chk("done_one_cycle_stall", 32'(DONE), 32'd0);

    // Ties and all-ones
    cur_w = '{14'd5, 14'd9, 14'd5, 14'd5};
    start_frame();
    run_frame(0, 1'b0);
    chk("tie_min_idx", 32'(MIN_IDX), 32'd0);
    @(negedge CLOCK);
    cur_w = '{14'h3FFF, 14'h3FFF, 14'h3FFF, 14'h3FFF};
    start_frame();
    run_frame(2, 1'b0);
    chk("ones_min_val", 32'(MIN_VAL), 32'd16383);
    chk("ones_min_idx", 32'(MIN_IDX), 32'd0);
    @(negedge CLOCK);

    // START mid-frame and bank change after snapshot are ignored
    cur_w = '{14'd900, 14'd33, 14'd1000, 14'd34};
    start_frame();
    run_frame(2, 1'b1);
    @(negedge CLOCK);

    // Asynchronous reset after the second transfer
    cur_w = '{14'd100, 14'd200, 14'd3, 14'd400};
    start_frame();
    @(negedge CLOCK);
    START = 1'b0;
    READY = 1'b1;
    @(negedge CLOCK);
    @(negedge CLOCK);
    chk("pre_rst_idx", 32'(IDX), 32'd2);
    #2 RESET_N = 1'b0;
    #1;
    chk("arst_dout", 32'(DOUT), 32'd0);
    chk("arst_idx", 32'(IDX), 32'd0);
    chk("arst_valid", 32'(VALID), 32'd0);
    chk("arst_busy", 32'(BUSY), 32'd0);
    chk("arst_minval", 32'(MIN_VAL), 32'd0);
    chk("arst_minidx", 32'(MIN_IDX), 32'd0);
    @(negedge CLOCK);
    chk("arst_no_done", 32'(DONE), 32'd0);
    RESET_N = 1'b1;
    READY = 1'b0;
    prev_min  = '0;
    prev_midx = '0;
    @(negedge CLOCK);
    chk("post_rst_no_done", 32'(DONE), 32'd0);
    start_frame();
    run_frame(0, 1'b0);
    @(negedge CLOCK);

    // START during the DONE cycle chains straight into the next frame
    cur_w = '{14'd50, 14'd60, 14'd70, 14'd45};
    start_frame();
    run_frame(0, 1'b0);
    cur_w = '{14'd8000, 14'd9, 14'd9, 14'd11};
    start_frame();
    run_frame(2, 1'b0);

    // Randomized frames, optionally chained, with small values to force ties
    for (int f = 0; f < 24; f++) begin
      for (int i = 0; i < NW; i++)
        cur_w[i] = ($urandom_range(0, 1) == 1) ? PB'($urandom_range(0, 3)) : PB'($urandom);
      if ($urandom_range(0, 1) == 1) @(negedge CLOCK);
      start_frame();
      run_frame(2, 1'($urandom_range(0, 1)));
    end
    @(negedge CLOCK);
    chk("final_idle_done", 32'(DONE), 32'd0);
    chk("final_idle_busy", 32'(BUSY), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
